// File: rtl/i2s_pkg.sv
// Shared FSM state, channel and default-width definitions for the I2S receiver.
package i2s_pkg;

    localparam int DATA_BITS_DEF = 24;
    localparam int CNT_BITS_DEF  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_t;

endpackage

// File: rtl/sync_ff.sv
// Two-flop synchronizer for asynchronous inputs; both stages clear to 0 on reset.
module sync_ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes sclk/lrclk/sdata, deserializes stereo slots, emits MSB-aligned pairs.
// Define I2S_RX_FRAME_ERR_EN to build the left/right slot-length check that drives frame_err.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int CNT_BITS  = CNT_BITS_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i2s_sclk,
    input  logic                        i2s_lrclk,
    input  logic                        i2s_sdata,
    output logic signed [DATA_BITS-1:0] left_out,
    output logic signed [DATA_BITS-1:0] right_out,
    output logic                        sample_valid,
    output logic                        frame_err
);

    localparam logic [CNT_BITS-1:0]  CNT_MAX = '1;
    localparam logic [DATA_BITS-1:0] MSB_POS = {1'b1, {(DATA_BITS-1){1'b0}}};

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_BITS'(1);
    endfunction

    // Stage p0: synchronized pins and sclk rising-edge strobe
    logic [2:0] sync_p0;
    logic       sclk_d_p0;
    logic       edge_p0;

    sync_ff #(.WIDTH(3)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({i2s_sclk, i2s_lrclk, i2s_sdata}),
        .q   (sync_p0)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sclk_d_p0 <= 1'b0;
        else      sclk_d_p0 <= sync_p0[2];
    end

    assign edge_p0 = sync_p0[2] & ~sclk_d_p0;

    // Stage p1: lrclk/sdata sampled on the sclk edge, boundary classification
    logic vld_p1, lr_p1, sd_p1, lr_prev;
    logic bnd_fall, bnd_rise, data_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            lr_p1   <= 1'b0;
            sd_p1   <= 1'b0;
            lr_prev <= 1'b0;
        end else begin
            vld_p1 <= edge_p0;
            if (edge_p0) begin
                lr_p1 <= sync_p0[1];
                sd_p1 <= sync_p0[0];
            end
            if (vld_p1) lr_prev <= lr_p1;
        end
    end

    // A boundary edge carries the previous slot's delay bit, so it never shifts data.
    assign bnd_fall = vld_p1 &  lr_prev & ~lr_p1;
    assign bnd_rise = vld_p1 & ~lr_prev &  lr_p1;
    assign data_p1  = vld_p1 & (lr_prev == lr_p1);

    state_t state, state_nx;
    logic   left_done, pair_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        left_done = 1'b0;
        pair_done = 1'b0;
        case (state)
            IDLE:    if (bnd_fall) state_nx = LEFT;
            LEFT:    if (bnd_rise) begin
                         state_nx  = RIGHT;
                         left_done = 1'b1;
                     end
            RIGHT:   if (bnd_fall) begin
                         state_nx  = LEFT;
                         pair_done = 1'b1;
                     end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p2: slot deserializer, left holding register and output pair
    logic [DATA_BITS-1:0]        slot_sr;
    logic [DATA_BITS-1:0]        slot_pos;
    logic [CNT_BITS-1:0]         bit_cnt;
    logic signed [DATA_BITS-1:0] hold;

    // slot_pos walks a one-hot from the MSB down, giving left alignment and dropping excess bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_sr      <= '0;
            slot_pos     <= '0;
            bit_cnt      <= '0;
            hold         <= '0;
            left_out     <= '0;
            right_out    <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= pair_done;
            if (bnd_fall || bnd_rise) begin
                slot_sr  <= '0;
                slot_pos <= MSB_POS;
                bit_cnt  <= '0;
            end else if (data_p1 && state != IDLE) begin
                if (sd_p1) slot_sr <= slot_sr | slot_pos;
                slot_pos <= slot_pos >> 1;
                bit_cnt  <= sat_inc(bit_cnt);
            end
            if (left_done) hold <= slot_sr;
            if (pair_done) begin
                left_out  <= hold;
                right_out <= slot_sr;
            end
        end
    end

`ifdef I2S_RX_FRAME_ERR_EN
    logic [CNT_BITS-1:0] left_len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_len  <= '0;
            frame_err <= 1'b0;
        end else begin
            if (left_done) left_len <= bit_cnt;
            if (pair_done && (left_len != bit_cnt || left_len == CNT_MAX || bit_cnt == CNT_MAX))
                frame_err <= 1'b1;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: directed frames plus randomized short-slot frames against a slot-level model.
module tb_i2s_rx;

    localparam int DB = 24;
`ifdef I2S_RX_FRAME_ERR_EN
    localparam logic FE_ON = 1'b1;
`else
    localparam logic FE_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i2s_sclk, i2s_lrclk, i2s_sdata;
    logic signed [DB-1:0] left_out, right_out;
    logic                 sample_valid, frame_err;

    i2s_rx #(.DATA_BITS(DB), .CNT_BITS(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .left_out     (left_out),
        .right_out    (right_out),
        .sample_valid (sample_valid),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, n_valid = 0, n_pushed = 0;
    logic [48:0] exp_q[$];

    // slot-level model state
    int          ph, slot_len, llen;
    bit          first;
    logic        prev_lr, exp_ferr;
    logic [23:0] slot_cap, lcap;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && sample_valid === 1'b1) begin
            logic [48:0] e;
            n_valid++;
            chk("valid_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pair", {15'd0, left_out, right_out, frame_err}, {15'd0, e});
            end
        end
    end

    // Slot of len sclk periods; period 0 is the boundary/delay bit, data bits follow MSB first from bits[63].
    task automatic send_slot(input logic lr, input int len, input logic [63:0] bits, input bit meas);
        logic        d;
        int          n, lat;
        logic [23:0] ones;
        if (first) first = 1'b0;
        else if (lr != prev_lr) begin
            if (!lr) begin
                if (ph == 2) begin
                    if (FE_ON && (llen != slot_len || llen == 63 || slot_len == 63)) exp_ferr = 1'b1;
                    exp_q.push_back({lcap, slot_cap, exp_ferr});
                    n_pushed++;
                end
                ph = 1;
            end else if (ph == 1) begin
                lcap = slot_cap;
                llen = slot_len;
                ph   = 2;
            end
        end
        prev_lr = lr;
        for (int k = 0; k < len; k++) begin
            if (k == 0 || k > 64) d = 1'($urandom_range(0, 1));
            else                  d = bits[64-k];
            i2s_sclk  = 1'b0;
            i2s_lrclk = lr;
            i2s_sdata = d;
            #20 i2s_sclk = 1'b1;
            if (meas && k == 0) begin
                lat = 0;
                while (sample_valid !== 1'b1 && lat < 10) begin
                    @(posedge clk);
                    #1 lat++;
                end
                checks++;
                assert (lat == 4 || lat == 5) else begin
                    errors++;
                    $error("FAIL latency got=%0d exp=4..5", lat);
                end
            end else begin
                #20;
            end
        end
        n        = (len - 1 < DB) ? len - 1 : DB;
        ones     = '1;
        slot_cap = bits[63:40] & ~(ones >> n);
        slot_len = (len - 1 > 63) ? 63 : len - 1;
    endtask

    task automatic frame(input int ll, input logic [63:0] lb, input int rl, input logic [63:0] rb,
                         input bit meas);
        send_slot(1'b0, ll, lb, meas);
        send_slot(1'b1, rl, rb, 1'b0);
    endtask

    task automatic reset_dut();
        i2s_sclk = 1'b0;
        #20 rst = 1'b0;
        ph       = 0;
        first    = 1'b1;
        exp_ferr = 1'b0;
        #40;
        chk("rst_left", {40'd0, left_out}, 64'd0);
        chk("rst_right", {40'd0, right_out}, 64'd0);
        chk("rst_valid", 64'(sample_valid), 64'd0);
        chk("rst_ferr", 64'(frame_err), 64'd0);
        rst = 1'b1;
        #20;
    endtask

    int n0;

    initial begin
        rst = 1'b0; i2s_sclk = 1'b0; i2s_lrclk = 1'b0; i2s_sdata = 1'b0;
        ph = 0; first = 1'b1; prev_lr = 1'b0; exp_ferr = 1'b0;
        slot_cap = '0; lcap = '0; slot_len = 0; llen = 0;
        #2;
        reset_dut();
        send_slot(1'b1, 3, 64'd0, 1'b0);

        // full-scale 24-bit data in 32-period slots
        for (int f = 0; f < 3; f++)
            frame(32, {24'h7FFFFF, 40'd0}, 32, {24'h800001, 40'd0}, f == 1);
        send_slot(1'b0, 4, 64'd0, 1'b0);
        chk("n_valid_fullscale", 64'(n_valid), 64'd3);
        chk("left_fullscale", {40'd0, left_out}, 64'h7FFFFF);
        chk("right_fullscale", {40'd0, right_out}, 64'h800001);
        send_slot(1'b1, 4, 64'd0, 1'b0);

        // 16 data bits after the delay bit: left-aligned, zero padded
        frame(17, {16'h1234, 48'd0}, 17, {16'hABCD, 48'd0}, 1'b0);
        send_slot(1'b0, 4, 64'd0, 1'b0);
        chk("left_16b", {40'd0, left_out}, 64'h123400);
        chk("right_16b", {40'd0, right_out}, 64'hABCD00);
        send_slot(1'b1, 4, 64'd0, 1'b0);

        // unequal slot lengths (32 vs 31 data bits), then good frames
        chk("ferr_before", 64'(frame_err), 64'd0);
        frame(33, {$urandom, $urandom}, 32, {$urandom, $urandom}, 1'b0);
        send_slot(1'b0, 4, 64'd0, 1'b0);
        chk("ferr_mismatch", 64'(frame_err), 64'(FE_ON));
        send_slot(1'b1, 4, 64'd0, 1'b0);
        frame(25, {$urandom, $urandom}, 25, {$urandom, $urandom}, 1'b0);
        frame(25, {$urandom, $urandom}, 25, {$urandom, $urandom}, 1'b0);
        send_slot(1'b0, 4, 64'd0, 1'b0);
        chk("ferr_sticky", 64'(frame_err), 64'(FE_ON));
        send_slot(1'b1, 4, 64'd0, 1'b0);

        // reset in the middle of a right slot
        send_slot(1'b0, 32, {$urandom, $urandom}, 1'b0);
        send_slot(1'b1, 10, {$urandom, $urandom}, 1'b0);
        reset_dut();
        n0 = n_valid;
        send_slot(1'b1, 22, {$urandom, $urandom}, 1'b0);
        send_slot(1'b0, 32, {$urandom, $urandom}, 1'b0);
        chk("partial_no_valid", 64'(n_valid), 64'(n0));
        chk("partial_outputs_zero", {16'd0, left_out, right_out}, 64'd0);
        send_slot(1'b1, 32, {24'h5A5A5A, 40'd0}, 1'b0);
        frame(32, {24'hC00003, 40'd0}, 32, {24'h0F0F0F, 40'd0}, 1'b0);
        send_slot(1'b0, 4, 64'd0, 1'b0);
        chk("after_reset_left", {40'd0, left_out}, 64'hC00003);
        chk("after_reset_right", {40'd0, right_out}, 64'h0F0F0F);
        send_slot(1'b1, 4, 64'd0, 1'b0);

        // over-long slots: excess bits dropped, counter saturates
        frame(70, {$urandom, $urandom}, 70, {$urandom, $urandom}, 1'b0);
        send_slot(1'b0, 4, 64'd0, 1'b0);
        chk("ferr_saturate", 64'(frame_err), 64'(FE_ON));
        send_slot(1'b1, 4, 64'd0, 1'b0);

        // randomized short slots with varying sclk phase
        reset_dut();
        send_slot(1'b1, 3, 64'd0, 1'b0);
        for (int f = 0; f < 1000; f++) begin
            #(2 * $urandom_range(0, 4));
            frame($urandom_range(2, 9), {$urandom, $urandom},
                  $urandom_range(2, 9), {$urandom, $urandom}, 1'b0);
        end
        send_slot(1'b0, 4, 64'd0, 1'b0);
        #200;
        chk("no_missed_valid", 64'(exp_q.size()), 64'd0);
        chk("valid_count", 64'(n_valid), 64'(n_pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
